// File: rtl/vector_map_pkg.sv
// Shared definitions for the vector map sequencer: FSM encoding and the
// helper that locates element k inside a packed vector.
package vector_map_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit offset of element k in a packed vector of width-bit elements.
    function automatic int unsigned elem_lsb(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

endpackage

// File: rtl/vector_map_credit_counter.sv
// Tracks how many elements have been issued to and collected from the shared
// unit, and derives the issue permission and last-collect flags.
module vector_map_credit_counter #(
    parameter int VECTOR_LENGTH   = 5,
    parameter int MAX_OUTSTANDING = 2,
    localparam int CW             = $clog2(VECTOR_LENGTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          issue,
    input  logic          collect,
    output logic [CW-1:0] issue_idx,
    output logic [CW-1:0] collect_idx,
    output logic          can_issue,
    output logic          has_outstanding,
    output logic          last_collect
);

    localparam logic [CW-1:0] VL_C   = CW'(VECTOR_LENGTH);
    localparam logic [CW-1:0] MO_C   = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] LAST_C = CW'(VECTOR_LENGTH - 1);

    logic [CW-1:0] issue_q;
    logic [CW-1:0] collect_q;
    logic [CW-1:0] outstanding;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            issue_q   <= '0;
            collect_q <= '0;
        end else if (clear) begin
            issue_q   <= '0;
            collect_q <= '0;
        end else begin
            // Issue and collect may both fire; each counter moves independently.
            if (issue)   issue_q   <= issue_q + 1'b1;
            if (collect) collect_q <= collect_q + 1'b1;
        end
    end

    assign outstanding     = issue_q - collect_q;
    assign issue_idx       = issue_q;
    assign collect_idx     = collect_q;
    assign can_issue       = (issue_q < VL_C) && (outstanding < MO_C);
    assign has_outstanding = (outstanding != '0);
    assign last_collect    = (collect_q == LAST_C);

endmodule

// File: rtl/vector_map_sequencer.sv
// Folds an element-wise vector map onto one shared function unit: captures a
// vector, issues elements in order, gathers in-order results, hands them on.
module vector_map_sequencer
    import vector_map_pkg::*;
#(
    parameter int ELEMENT_WIDTH   = 4,
    parameter int VECTOR_LENGTH   = 5,
    parameter int MAX_OUTSTANDING = 2,
    localparam int VW             = VECTOR_LENGTH * ELEMENT_WIDTH,
    localparam int IW             = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1,
    localparam int CW             = $clog2(VECTOR_LENGTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [VW-1:0]            i_vector,
    input  logic                     i_vector_valid,
    output logic                     o_vector_ready,
    output logic [ELEMENT_WIDTH-1:0] o_element,
    output logic [IW-1:0]            o_element_index,
    output logic                     o_element_valid,
    input  logic                     i_element_ready,
    input  logic [ELEMENT_WIDTH-1:0] i_result,
    input  logic                     i_result_valid,
    output logic [VW-1:0]            o_vector,
    output logic                     o_vector_valid,
    input  logic                     i_vector_ready,
    output logic                     o_busy,
    output state_t                   o_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready and payload holds while valid & !ready.
    // The result channel has no ready: the unit returns one result per
    // i_result_valid, in issue order.

    state_t state_q, state_d;

    logic [VW-1:0]            in_q;
    logic [VW-1:0]            out_q;
    logic [ELEMENT_WIDTH-1:0] elem_mux;
    logic [CW-1:0]            issue_idx;
    logic [CW-1:0]            collect_idx;
    logic                     can_issue;
    logic                     has_outstanding;
    logic                     last_collect;
    logic                     accept;
    logic                     issue_fire;
    logic                     collect_fire;

    assign accept       = (state_q == IDLE) && i_vector_valid;
    assign issue_fire   = o_element_valid && i_element_ready;
    assign collect_fire = (state_q == BUSY) && i_result_valid && has_outstanding;

    vector_map_credit_counter #(
        .VECTOR_LENGTH   (VECTOR_LENGTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clock           (clock),
        .reset_n         (reset_n),
        .clear           (accept),
        .issue           (issue_fire),
        .collect         (collect_fire),
        .issue_idx       (issue_idx),
        .collect_idx     (collect_idx),
        .can_issue       (can_issue),
        .has_outstanding (has_outstanding),
        .last_collect    (last_collect)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        o_vector_ready  = 1'b0;
        o_element_valid = 1'b0;
        o_vector_valid  = 1'b0;
        o_busy          = 1'b1;
        case (state_q)
            IDLE: begin
                o_vector_ready = 1'b1;
                o_busy         = 1'b0;
                if (i_vector_valid) state_d = BUSY;
            end
            BUSY: begin
                o_element_valid = can_issue;
                if (collect_fire && last_collect) state_d = DONE;
            end
            DONE: begin
                o_vector_valid = 1'b1;
                if (i_vector_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_q  <= '0;
            out_q <= '0;
        end else begin
            if (accept) in_q <= i_vector;
            if (collect_fire) begin
                for (int k = 0; k < VECTOR_LENGTH; k++) begin
                    if (collect_idx == CW'(k))
                        out_q[elem_lsb(k, ELEMENT_WIDTH) +: ELEMENT_WIDTH] <= i_result;
                end
            end
        end
    end

    // issue_idx reaches VECTOR_LENGTH once all elements are out; the mux then yields 0.
    always_comb begin
        elem_mux = '0;
        for (int k = 0; k < VECTOR_LENGTH; k++) begin
            if (issue_idx == CW'(k))
                elem_mux = in_q[elem_lsb(k, ELEMENT_WIDTH) +: ELEMENT_WIDTH];
        end
    end

    assign o_element       = elem_mux;
    assign o_element_index = issue_idx[IW-1:0];
    assign o_vector        = out_q;
    assign o_state         = state_q;

endmodule
